// File: rtl/control_sequencer.sv
// Microprogram sequencer: steps through a 16-entry program store, issuing control
// words to a datapath, with zero-test branching and a watchdog on runaway programs.
module control_sequencer #(
  parameter int WIDTH    = 4,
  parameter int CTRLWORD = 14,
  parameter int DEPTH    = 16,
  parameter int MAXSTEPS = 255,
  localparam int AW      = $clog2(DEPTH),
  localparam int IW      = CTRLWORD + 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_prog_we,
  input  logic [AW-1:0]       i_prog_addr,
  input  logic [IW-1:0]       i_prog_data,
  input  logic [WIDTH-1:0]    i_dp_out,
  output logic [CTRLWORD-1:0] o_control,
  output logic                o_ctrl_valid,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [AW-1:0]       o_pc
);

  localparam logic [7:0] STEP_LIMIT = 8'(MAXSTEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ISSUE = 2'b00,
    OP_JZ    = 2'b01,
    OP_JMP   = 2'b10,
    OP_HALT  = 2'b11
  } op_t;

  state_t              r_state;
  logic [IW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_pc;
  logic [7:0]          r_steps;
  logic [CTRLWORD-1:0] r_control;
  logic                r_ctrl_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic [IW-1:0]       w_instr;
  op_t                 w_op;
  logic [AW-1:0]       w_target;
  logic [AW-1:0]       w_pc_inc;
  logic                w_dp_zero;
  logic                w_wd_trip;
  logic                w_prog_wr;

  assign w_instr   = r_mem[r_pc];
  assign w_op      = op_t'(w_instr[IW-1:IW-2]);
  assign w_target  = w_instr[AW-1:0];
  assign w_pc_inc  = r_pc + AW'(1);
  assign w_dp_zero = (i_dp_out == '0);
  // The instruction that would be number MAXSTEPS is replaced by the abort.
  assign w_wd_trip = (r_steps >= STEP_LIMIT);
  assign w_prog_wr = i_prog_we && !i_rst &&
                     ((r_state == S_IDLE) || (r_state == S_DONE));

  // Program store: no reset so the loaded program survives rst.
  always_ff @(posedge i_clk) begin
    if (w_prog_wr) begin
      r_mem[i_prog_addr] <= i_prog_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_steps      <= 8'd0;
      r_control    <= '0;
      r_ctrl_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_ctrl_valid <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_control <= '0;
          if (i_start) begin
            r_pc    <= '0;
            r_steps <= 8'd0;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          r_steps   <= (r_steps == 8'hFF) ? r_steps : r_steps + 8'd1;
          r_control <= '0;
          if ((w_op != OP_HALT) && w_wd_trip) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            case (w_op)
              OP_ISSUE: begin
                r_control    <= w_instr[CTRLWORD-1:0];
                r_ctrl_valid <= 1'b1;
                r_pc         <= w_pc_inc;
              end
              OP_JZ: begin
                r_pc <= w_dp_zero ? w_target : w_pc_inc;
              end
              OP_JMP: begin
                r_pc <= w_target;
              end
              OP_HALT: begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end
              default: begin
                r_pc <= w_pc_inc;
              end
            endcase
          end
        end
        S_DONE: begin
          r_control <= '0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_control <= '0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign o_control    = r_control;
  assign o_ctrl_valid = r_ctrl_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_pc         = r_pc;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed programs push expected issue /
// halt / abort events; a negedge monitor pops and compares as the DUT produces them.
module tb_control_sequencer;

  localparam int WIDTH    = 4;
  localparam int CTRLWORD = 14;
  localparam logic [1:0] K_ISSUE = 2'd0;
  localparam logic [1:0] K_DONE  = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd2;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                prog_we;
  logic [3:0]          prog_addr;
  logic [15:0]         prog_data;
  logic [WIDTH-1:0]    dp_out;
  logic [CTRLWORD-1:0] control;
  logic                ctrl_valid;
  logic                busy;
  logic                done;
  logic                err;
  logic [3:0]          pc;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_err = 1'b0;

  control_sequencer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_prog_we   (prog_we),
    .i_prog_addr (prog_addr),
    .i_prog_data (prog_data),
    .i_dp_out    (dp_out),
    .o_control   (control),
    .o_ctrl_valid(ctrl_valid),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (err),
    .o_pc        (pc)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push(input logic [1:0] k, input logic [15:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sb_q.push_back(e);
  endfunction

  // Monitor: every issued word, halt pulse and abort edge must match the next expectation.
  always @(negedge clk) begin
    if (ctrl_valid === 1'b1) begin
      check("sb_pending_issue", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("issue_kind", 32'(K_ISSUE), 32'(mon_e.kind));
        check("issue_word", 32'(control), 32'(mon_e.val));
      end
    end
    if (done === 1'b1) begin
      check("sb_pending_done", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("done_kind", 32'(K_DONE), 32'(mon_e.kind));
        check("done_pc", 32'(pc), 32'(mon_e.val));
        check("done_not_busy", 32'(busy), 32'd0);
      end
    end
    if ((err === 1'b1) && (prev_err !== 1'b1)) begin
      check("sb_pending_err", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("err_kind", 32'(K_ERR), 32'(mon_e.kind));
        check("err_control_zero", 32'(control), 32'd0);
        check("err_done_low", 32'(done), 32'd0);
      end
    end
    prev_err <= err;
  end

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  // Returns at the negedge after the start edge (first RUN cycle).
  task automatic run_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (((busy === 1'b1) || (done === 1'b1)) && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 2000), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=hung required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cnt;
    rst       = 1'b1;
    start     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = 4'd0;
    prog_data = 16'd0;
    dp_out    = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_control", 32'(control), 32'd0);
    check("rst_valid",   32'(ctrl_valid), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_done",    32'(done), 32'd0);
    check("rst_error",   32'(err), 32'd0);
    check("rst_pc",      32'(pc), 32'd0);
    rst = 1'b0;

    // Single issue then halt.
    load(4'd0, 16'h0A22);
    load(4'd1, 16'hC000);
    push(K_ISSUE, 16'h0A22);
    push(K_DONE, 16'd1);
    run_start();
    check("t1_busy_first", 32'(busy), 32'd1);
    check("t1_valid_first", 32'(ctrl_valid), 32'd0);
    @(negedge clk);
    check("t1_latency_word", 32'(control), 32'h0A22);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd1);
    wait_idle("t1_idle");
    check("t1_done_cleared", 32'(done), 32'd0);

    // JZ taken (dp_out == 0) and not taken (dp_out == 5).
    load(4'd0, 16'h3822);
    load(4'd1, 16'h4003);
    load(4'd2, 16'hC000);
    load(4'd3, 16'hC000);
    dp_out = 4'd0;
    push(K_ISSUE, 16'h3822);
    push(K_DONE, 16'd3);
    run_start();
    check("t2a_pc0", 32'(pc), 32'd0);
    @(negedge clk);
    check("t2a_pc1", 32'(pc), 32'd1);
    @(negedge clk);
    check("t2a_pc3", 32'(pc), 32'd3);
    wait_idle("t2a_idle");
    dp_out = 4'd5;
    push(K_ISSUE, 16'h3822);
    push(K_DONE, 16'd2);
    run_start();
    check("t2b_pc0", 32'(pc), 32'd0);
    @(negedge clk);
    check("t2b_pc1", 32'(pc), 32'd1);
    @(negedge clk);
    check("t2b_pc2", 32'(pc), 32'd2);
    wait_idle("t2b_idle");

    // Runaway JMP 0 loop trips the watchdog.
    load(4'd0, 16'h8000);
    push(K_ERR, 16'd0);
    run_start();
    cnt = 0;
    while ((busy === 1'b1) && (cnt < 1000)) begin
      cnt++;
      @(negedge clk);
    end
    check("t3_busy_cycles", 32'(cnt), 32'd255);
    check("t3_error", 32'(err), 32'd1);
    check("t3_done_low", 32'(done), 32'd0);
    check("t3_control_zero", 32'(control), 32'd0);
    wait_idle("t3_idle");
    check("t3_error_sticky", 32'(err), 32'd1);

    // PC wrap 15 -> 0: JZ 14 first, then JZ falls through to HALT.
    load(4'd0, 16'h400E);
    load(4'd1, 16'hC000);
    load(4'd14, 16'h0123);
    load(4'd15, 16'h0456);
    dp_out = 4'd0;
    push(K_ISSUE, 16'h0123);
    push(K_ISSUE, 16'h0456);
    push(K_DONE, 16'd1);
    run_start();
    check("t4_error_cleared", 32'(err), 32'd0);
    @(negedge clk);
    check("t4_pc14", 32'(pc), 32'd14);
    dp_out = 4'd5;
    @(negedge clk);
    check("t4_pc15", 32'(pc), 32'd15);
    @(negedge clk);
    check("t4_pc_wrap", 32'(pc), 32'd0);
    wait_idle("t4_idle");

    // Reset mid-run, with a write attempt coincident with rst.
    load(4'd0, 16'h0111);
    load(4'd1, 16'h0222);
    load(4'd2, 16'h0333);
    load(4'd3, 16'h0444);
    load(4'd4, 16'hC000);
    push(K_ISSUE, 16'h0111);
    push(K_ISSUE, 16'h0222);
    run_start();
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = 16'hC000;
    @(negedge clk);
    check("t5_rst_control", 32'(control), 32'd0);
    check("t5_rst_valid",   32'(ctrl_valid), 32'd0);
    check("t5_rst_busy",    32'(busy), 32'd0);
    check("t5_rst_pc",      32'(pc), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    prog_we = 1'b0;

    // Restart with a write and a start injected mid-run; output must be unperturbed.
    push(K_ISSUE, 16'h0111);
    push(K_ISSUE, 16'h0222);
    push(K_ISSUE, 16'h0333);
    push(K_ISSUE, 16'h0444);
    push(K_DONE, 16'd4);
    run_start();
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 4'd2;
    prog_data = 16'hC000;
    start     = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    start   = 1'b0;
    wait_idle("t6_idle");

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
